sr_latch_trng_array: RTL

Parametrised multi-channel SR-latch metastability entropy harvester, successor to the single-latch metastable experiment. It sequences excitation of NUM_CH external SR-latch cells, synchronises and samples their resolved outputs, and combines them into one raw bit per sample (XOR or Von Neumann debiased). It packs raw bits into WORD_W-bit words and delivers them over a valid/ready port. Per-channel stuck detection and a repetition-count health test guard the output.

---
 rtl/sr_latch_trng_array.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sr_latch_trng_array.sv
// Multi-channel SR-latch entropy harvester: excites NUM_CH external latch cells, samples
// their resolved outputs and packs XOR / Von Neumann combined bits into health-checked words.
module sr_latch_trng_array #(
  parameter int NUM_CH     = 8,
  parameter int WORD_W     = 32,
  parameter int EXCITE_CYC = 2,
  parameter int SETTLE_CYC = 4,
  parameter int RCT_LIMIT  = 32
) (
  input  logic              ref_clk_in,
  input  logic              rst_n_in,
  input  logic              en_in,
  input  logic              mode_in,
  output logic              excite_out,
  input  logic [NUM_CH-1:0] latch_q_in,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid_out,
  input  logic              data_ready_in,
  output logic [NUM_CH-1:0] ch_stuck_out,
  output logic              health_fail_out
);
  localparam int MAX_CYC = (EXCITE_CYC > SETTLE_CYC) ? EXCITE_CYC : SETTLE_CYC;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam int RW = $clog2(RCT_LIMIT + 1);
  localparam int BW = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {ST_IDLE, ST_EXCITE, ST_SETTLE, ST_SAMPLE, ST_HOLD} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cyc_reg;
  logic [NUM_CH-1:0] sync1_reg, sync2_reg, ch_prev_reg, stuck_reg, stuck_hit;
  logic [RW-1:0]     rct_cnt_reg, rct_cnt_next;
  logic              raw_prev_reg, health_reg;
  logic              mode_reg, vn_pend_reg, vn_first_reg;
  logic [WORD_W-1:0] shift_reg, out_reg;
  logic [BW-1:0]     bit_cnt_reg;
  logic              valid_reg;
  logic              sample_fire, raw_bit, bit_ok, bit_val;
  logic              word_full, load_out, word_done, fail_now;

  always_ff @(posedge ref_clk_in) begin
    if (!rst_n_in) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= latch_q_in;
      sync2_reg <= sync1_reg;
    end
  end

  // Per-channel run-length counter of identical samples; hitting the limit marks the cell stuck.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [RW-1:0] cnt_reg, cnt_next;
    always_comb begin
      cnt_next = RW'(1);
      if (sync2_reg[gi] == ch_prev_reg[gi])
        cnt_next = (cnt_reg < RW'(RCT_LIMIT)) ? cnt_reg + RW'(1) : cnt_reg;
    end
    assign stuck_hit[gi] = (cnt_next == RW'(RCT_LIMIT));
    always_ff @(posedge ref_clk_in) begin
      if (!rst_n_in)        cnt_reg <= '0;
      else if (sample_fire) cnt_reg <= cnt_next;
    end
  end

  assign raw_bit = ^(sync2_reg & ~stuck_reg);

  always_comb begin
    rct_cnt_next = RW'(1);
    if (raw_bit == raw_prev_reg)
      rct_cnt_next = (rct_cnt_reg < RW'(RCT_LIMIT)) ? rct_cnt_reg + RW'(1) : rct_cnt_reg;
  end

  assign fail_now = sample_fire &&
                    ((rct_cnt_next == RW'(RCT_LIMIT)) || (&(stuck_reg | stuck_hit)));

  // Von Neumann keeps the first bit of an unequal pair; XOR mode accepts every raw bit.
  always_comb begin
    bit_ok  = 1'b0;
    bit_val = raw_bit;
    if (!mode_reg) begin
      bit_ok = 1'b1;
    end else if (vn_pend_reg) begin
      bit_ok  = (vn_first_reg != raw_bit);
      bit_val = vn_first_reg;
    end
  end

  assign word_full = (bit_cnt_reg == BW'(WORD_W));
  assign load_out  = word_full && (!valid_reg || data_ready_in);
  assign word_done = sample_fire && bit_ok && (bit_cnt_reg == BW'(WORD_W - 1));

  always_ff @(posedge ref_clk_in) begin
    if (!rst_n_in) begin
      state_reg <= ST_IDLE;
      cyc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cyc_reg   <= (state_next != state_reg) ? '0 : cyc_reg + CW'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (en_in && !health_reg && (!word_full || load_out)) state_next = ST_EXCITE;
      ST_EXCITE: if (cyc_reg == CW'(EXCITE_CYC - 1)) state_next = ST_SETTLE;
      ST_SETTLE: if (cyc_reg == CW'(SETTLE_CYC - 1)) state_next = ST_SAMPLE;
      ST_SAMPLE: state_next = (word_done && valid_reg && !fail_now) ? ST_HOLD : ST_IDLE;
      ST_HOLD:   if (load_out) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    if (health_reg) state_next = ST_IDLE;
  end

  always_comb begin
    excite_out  = (state_reg == ST_EXCITE);
    sample_fire = (state_reg == ST_SAMPLE);
  end

  always_ff @(posedge ref_clk_in) begin
    if (!rst_n_in) begin
      ch_prev_reg  <= '0;
      stuck_reg    <= '0;
      rct_cnt_reg  <= '0;
      raw_prev_reg <= 1'b0;
      health_reg   <= 1'b0;
      mode_reg     <= 1'b0;
      vn_pend_reg  <= 1'b0;
      vn_first_reg <= 1'b0;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      out_reg      <= '0;
      valid_reg    <= 1'b0;
    end else begin
      // Mode only switches on a word boundary with no half pair outstanding.
      if (!sample_fire && bit_cnt_reg == '0 && !vn_pend_reg) mode_reg <= mode_in;
      if (sample_fire) begin
        ch_prev_reg  <= sync2_reg;
        stuck_reg    <= stuck_reg | stuck_hit;
        rct_cnt_reg  <= rct_cnt_next;
        raw_prev_reg <= raw_bit;
        if (mode_reg) begin
          vn_pend_reg  <= !vn_pend_reg;
          vn_first_reg <= raw_bit;
        end
        if (bit_ok) begin
          shift_reg   <= {shift_reg[WORD_W-2:0], bit_val};
          bit_cnt_reg <= bit_cnt_reg + BW'(1);
        end
      end else if (load_out) begin
        shift_reg   <= '0;
        bit_cnt_reg <= '0;
      end
      if (load_out) begin
        out_reg   <= shift_reg;
        valid_reg <= 1'b1;
      end else if (valid_reg && data_ready_in) begin
        valid_reg <= 1'b0;
      end
      if (fail_now) begin
        health_reg  <= 1'b1;
        valid_reg   <= 1'b0;
        out_reg     <= '0;
        shift_reg   <= '0;
        bit_cnt_reg <= '0;
        vn_pend_reg <= 1'b0;
      end
    end
  end

  assign data_out        = out_reg;
  assign data_valid_out  = valid_reg;
  assign ch_stuck_out    = stuck_reg;
  assign health_fail_out = health_reg;
endmodule
